// File: rtl/burst_ram_pkg.sv
// Shared types and command encodings for the burst-RAM responder.
package burst_ram_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE,
        ST_READ_WAIT,
        ST_READ
    } br_state_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/burst_ram_mem.sv
// Single-port block RAM with byte write enables and a registered one-cycle read.
module burst_ram_mem #(
    parameter int    ADDR_W    = 8,
    parameter int    DATA_W    = 64,
    parameter string DATA_FILE = ""
) (
    input  logic                clk,
    input  logic                we,
    input  logic                re,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/burst_ram_responder.sv
// Responder end of the br_* burst interface, serving bursts from on-chip RAM
// with the PSRAM controller's power-up busy, fixed read latency and beat streaming.
module burst_ram_responder
    import burst_ram_pkg::*;
#(
    parameter int    RAM_DEPTH_BITWIDTH      = 8,
    parameter int    RAM_BURST_DATA_COUNT    = 4,
    parameter int    RAM_BURST_DATA_BITWIDTH = 64,
    parameter int    READ_LATENCY            = 4,
    parameter int    INIT_CYCLES             = 8,
    parameter string DATA_FILE               = ""
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 br_cmd,
    input  logic                                 br_cmd_en,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    output logic                                 br_rd_data_valid,
    output logic                                 br_busy
);

    localparam int AW     = RAM_DEPTH_BITWIDTH;
    localparam int DW     = RAM_BURST_DATA_BITWIDTH;
    localparam int BEAT_W = $clog2(RAM_BURST_DATA_COUNT);
    localparam int LAT_W  = $clog2(READ_LATENCY + 1);
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RAM_BURST_DATA_COUNT - 1);
    localparam logic [LAT_W-1:0]  LAST_WAIT = LAT_W'(READ_LATENCY - 1);
    localparam logic [INIT_W-1:0] LAST_INIT = INIT_W'(INIT_CYCLES - 1);

    br_state_e          state, state_n;
    logic [INIT_W-1:0]  init_cnt;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [LAT_W-1:0]   lat_cnt;
    logic [AW-1:0]      burst_base;
    logic               accept;
    logic               mem_we;
    logic               mem_re;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_rdata;

    // Burst addresses wrap modulo the memory depth through plain truncation.
    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0]     base,
                                                 input logic [BEAT_W-1:0] idx);
        return base + AW'(idx);
    endfunction

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = beat_addr(burst_base, beat_cnt);
        case (state)
            ST_INIT: begin
                if (init_cnt == LAST_INIT) state_n = ST_IDLE;
            end
            ST_IDLE: begin
                mem_addr = br_addr;
                if (br_cmd_en) begin
                    accept = 1'b1;
                    if (br_cmd == CMD_WRITE) begin
                        mem_we  = 1'b1;
                        state_n = ST_WRITE;
                    end else if (READ_LATENCY == 1) begin
                        mem_re  = 1'b1;
                        state_n = ST_READ;
                    end else begin
                        state_n = ST_READ_WAIT;
                    end
                end
            end
            ST_WRITE: begin
                mem_we = 1'b1;
                if (beat_cnt == LAST_BEAT) state_n = ST_IDLE;
            end
            ST_READ_WAIT: begin
                // The RAM read takes one cycle, so beat 0 is fetched in the last wait cycle.
                mem_addr = burst_base;
                if (lat_cnt == LAST_WAIT) begin
                    mem_re  = 1'b1;
                    state_n = ST_READ;
                end
            end
            ST_READ: begin
                mem_addr = beat_addr(burst_base, beat_cnt + BEAT_W'(1));
                if (beat_cnt == LAST_BEAT) state_n = ST_IDLE;
                else                       mem_re  = 1'b1;
            end
            default: state_n = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_INIT;
            init_cnt         <= '0;
            beat_cnt         <= '0;
            lat_cnt          <= '0;
            br_busy          <= 1'b1;
            br_rd_data_valid <= 1'b0;
        end else begin
            state            <= state_n;
            br_busy          <= (state_n != ST_IDLE);
            br_rd_data_valid <= (state_n == ST_READ);
            case (state)
                ST_INIT: begin
                    if (init_cnt != LAST_INIT) init_cnt <= init_cnt + INIT_W'(1);
                end
                ST_IDLE: begin
                    if (accept) begin
                        beat_cnt <= (br_cmd == CMD_WRITE) ? BEAT_W'(1) : '0;
                        lat_cnt  <= LAT_W'(1);
                    end
                end
                ST_WRITE, ST_READ: beat_cnt <= beat_cnt + BEAT_W'(1);
                ST_READ_WAIT:      lat_cnt  <= lat_cnt + LAT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) burst_base <= br_addr;
    end

    burst_ram_mem #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .DATA_FILE (DATA_FILE)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .be    (~br_data_mask),
        .wdata (br_wr_data),
        .rdata (mem_rdata)
    );

    // The RAM output register feeds the port directly; the valid flag keeps idle data at zero.
    assign br_rd_data = br_rd_data_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_burst_ram_responder.sv
// Scoreboard bench for burst_ram_responder at default parameters.
module tb_burst_ram_responder;

    localparam int AW    = 8;
    localparam int CNT   = 4;
    localparam int DW    = 64;
    localparam int LAT   = 4;
    localparam int INITC = 8;

    logic              clk;
    logic              rst;
    logic              br_cmd;
    logic              br_cmd_en;
    logic [AW-1:0]     br_addr;
    logic [DW-1:0]     br_wr_data;
    logic [DW/8-1:0]   br_data_mask;
    logic [DW-1:0]     br_rd_data;
    logic              br_rd_data_valid;
    logic              br_busy;

    burst_ram_responder #(
        .RAM_DEPTH_BITWIDTH      (AW),
        .RAM_BURST_DATA_COUNT    (CNT),
        .RAM_BURST_DATA_BITWIDTH (DW),
        .READ_LATENCY            (LAT),
        .INIT_CYCLES             (INITC),
        .DATA_FILE               ("")
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_wr_data       (br_wr_data),
        .br_data_mask     (br_data_mask),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid),
        .br_busy          (br_busy)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model [2**AW];
    int            cyc_cnt = 0;
    int            n_chk   = 0;
    int            n_err   = 0;
    logic [DW-1:0] wd [CNT];
    logic [7:0]    wm [CNT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt++;

    initial begin
        #500000;
        $display("FAIL timeout got=%0d want=%0d", cyc_cnt, 0);
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic void mdl_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input logic [7:0] m);
        for (int b = 0; b < DW/8; b++)
            if (!m[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (br_rd_data_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rd_data", br_rd_data, e.data);
                chk("rd_cycle", 64'(cyc_cnt), 64'(e.cyc));
            end
        end else begin
            chk("rd_idle_zero", br_rd_data, 64'd0);
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 200 && br_busy; i++) cyc();
        chk("idle_wait", 64'(br_busy), 64'd0);
    endtask

    task automatic init_release();
        rst = 1'b0;
        for (int e = 1; e <= INITC; e++) begin
            cyc();
            chk("init_busy", 64'(br_busy), 64'(e < INITC));
            chk("init_valid", 64'(br_rd_data_valid), 64'd0);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a);
        wait_idle();
        br_cmd = 1'b1; br_cmd_en = 1'b1; br_addr = a;
        br_wr_data = wd[0]; br_data_mask = wm[0];
        for (int k = 0; k < CNT; k++) mdl_write(a + AW'(k), wd[k], wm[k]);
        cyc();
        br_cmd_en = 1'b0;
        for (int k = 1; k < CNT; k++) begin
            chk("wr_busy", 64'(br_busy), 64'd1);
            br_wr_data = wd[k]; br_data_mask = wm[k];
            cyc();
        end
        chk("wr_done", 64'(br_busy), 64'd0);
    endtask

    task automatic push_read(input logic [AW-1:0] a);
        int acc;
        acc = cyc_cnt;
        for (int k = 0; k < CNT; k++) begin
            logic [AW-1:0] ak;
            ak = a + AW'(k);
            sb.push_back('{data: model[ak], cyc: acc + LAT + k});
        end
        br_cmd = 1'b0; br_cmd_en = 1'b1; br_addr = a;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input bit inject);
        wait_idle();
        push_read(a);
        cyc();
        br_cmd_en = 1'b0;
        chk("rd_busy", 64'(br_busy), 64'd1);
        for (int c = 1; c < LAT + CNT; c++) begin
            if (inject && c == 2) begin
                br_cmd = 1'b1; br_cmd_en = 1'b1; br_addr = a;
                br_wr_data = 64'hDEAD_BEEF_DEAD_BEEF; br_data_mask = 8'h00;
            end else begin
                br_cmd_en = 1'b0;
            end
            cyc();
        end
        chk("rd_done", 64'(br_busy), 64'd0);
        chk("rd_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; br_cmd = 1'b0; br_cmd_en = 1'b0; br_addr = '0;
        br_wr_data = '0; br_data_mask = '0;
        cyc(); cyc();
        chk("rst_busy", 64'(br_busy), 64'd1);
        chk("rst_valid", 64'(br_rd_data_valid), 64'd0);
        chk("rst_data", br_rd_data, 64'd0);
        init_release();

        // Round trip at 0x10, read accepted right after the write completes.
        wd = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        wm = '{8'h00, 8'h00, 8'h00, 8'h00};
        do_write(8'h10);
        do_read(8'h10, 1'b0);

        // Byte mask merge.
        wd = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        do_write(8'h20);
        wd = '{64'h1234_5678_9ABC_DEF0, 64'h0, 64'h0, 64'h0};
        wm = '{8'h0F, 8'hFF, 8'hFF, 8'hFF};
        do_write(8'h20);
        do_read(8'h20, 1'b0);

        // Wrap-around from the top word.
        wd = '{64'h0000_0000_0000_0A00, 64'h0000_0000_0000_0A01,
               64'h0000_0000_0000_0A02, 64'h0000_0000_0000_0A03};
        wm = '{8'h00, 8'h00, 8'h00, 8'h00};
        do_write(8'h00);
        wd = '{64'hAAAA_AAAA_0000_00FE, 64'hBBBB_BBBB_0000_00FF,
               64'hCCCC_CCCC_0000_0000, 64'hDDDD_DDDD_0000_0001};
        do_write(8'hFE);
        do_read(8'h00, 1'b0);
        do_read(8'hFE, 1'b0);

        // Write attempted while a read is in flight.
        do_read(8'h10, 1'b1);
        do_read(8'h10, 1'b0);

        // Reset in cycle 5 of a read.
        wait_idle();
        push_read(8'h10);
        cyc();
        br_cmd_en = 1'b0;
        repeat (4) cyc();
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_valid", 64'(br_rd_data_valid), 64'd0);
        chk("midrst_busy", 64'(br_busy), 64'd1);
        chk("midrst_data", br_rd_data, 64'd0);
        cyc(); cyc();
        init_release();
        do_read(8'h10, 1'b0);
        do_read(8'h20, 1'b0);

        cyc();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
